// File: rtl/clkgen_pkg.sv
// Shared constants and FSM encoding for the multiphase non-overlapping clock generator.
package clkgen_pkg;
  localparam int CLKGEN_CNT_W    = 6;
  localparam int CLKGEN_DEF_HALF = 8;
  localparam int CLKGEN_DEF_DEAD = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/multiphase_nonoverlap_clkgen_if.sv
// Active configuration bus from the top-level config handshake to the phase slices.
interface clkgen_cfg_if
  import clkgen_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CLKGEN_CNT_W
);
  logic [CNT_W-1:0]            half;
  logic [CNT_W-1:0]            dead;
  logic [NUM_CH*(CNT_W+1)-1:0] phase;
  state_e                      state;

  modport master (output half, dead, phase, state);
  modport slave  (input  half, dead, phase, state);
endinterface

// File: rtl/multiphase_nonoverlap_clkgen_slice.sv
// One output channel pair: phase-shifted position, dead-time windows, registered pins.
module nonoverlap_phase_slice
  import clkgen_pkg::*;
#(
  parameter int CNT_W = CLKGEN_CNT_W,
  parameter int CH    = 0
)(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [CNT_W:0]   cnt_i,
  clkgen_cfg_if.slave      cfg,
  output logic             mod_o,
  output logic             modn_o
);
  localparam int PW = CNT_W + 1;

  logic [PW-1:0] phase;
  logic [PW-1:0] period;
  logic [PW-1:0] half_w;
  logic [PW-1:0] dead_w;
  logic [PW-1:0] pos;
  logic          mod_d, modn_d;
  logic          mod_q, modn_q;

  assign phase  = cfg.phase[CH*PW +: PW];
  assign period = {cfg.half, 1'b0};
  assign half_w = {1'b0, cfg.half};
  assign dead_w = {1'b0, cfg.dead};

  // Subtract the other way round on underflow so nothing ever exceeds PW bits.
  always_comb begin
    pos    = (cnt_i >= phase) ? (cnt_i - phase) : (period - (phase - cnt_i));
    mod_d  = run_i && (pos >= dead_w) && (pos < half_w);
    modn_d = run_i && (pos >= (half_w + dead_w)) && (pos < period);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mod_q  <= 1'b0;
      modn_q <= 1'b0;
    end else begin
      mod_q  <= mod_d;
      modn_q <= modn_d;
    end
  end

  assign mod_o  = mod_q;
  assign modn_o = modn_q;
endmodule

// File: rtl/multiphase_nonoverlap_clkgen.sv
// Base counter, run/idle FSM and shadow/active config handshake; channels live in the slices.
module multiphase_nonoverlap_clkgen
  import clkgen_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = CLKGEN_CNT_W,
  parameter int DEF_HALF = CLKGEN_DEF_HALF,
  parameter int DEF_DEAD = CLKGEN_DEF_DEAD
)(
  input  logic                        CLK_IN,
  input  logic                        RESET_N,
  input  logic                        ENABLE,
  input  logic [CNT_W-1:0]            CFG_HALF,
  input  logic [CNT_W-1:0]            CFG_DEAD,
  input  logic [NUM_CH*CNT_W+NUM_CH-1:0] PHASE_SEL,
  input  logic                        CFG_LOAD,
  output logic                        CFG_PENDING,
  output logic                        CFG_ERR,
  output logic [NUM_CH-1:0]           CLK_OUT_MOD,
  output logic [NUM_CH-1:0]           CLK_OUT_MODN,
  output logic                        SYNC
);
  localparam int PW = CNT_W + 1;

  state_e               state_q;
  logic [PW-1:0]        cnt_q;
  logic [CNT_W-1:0]     act_half_q, act_dead_q, shd_half_q, shd_dead_q;
  logic [NUM_CH*PW-1:0] act_phase_q, shd_phase_q;
  logic                 pending_q, err_q, sync_q;

  logic [PW-1:0]        period;
  logic                 wrap;
  logic                 apply;
  logic                 load_legal;

  assign period = {act_half_q, 1'b0};
  assign wrap   = (cnt_q == (period - PW'(1)));
  // Shadow goes live only at a period boundary, or straight away when not running.
  assign apply  = pending_q && (!ENABLE || (state_q == ST_IDLE) || wrap);

  always_comb begin
    load_legal = (CFG_HALF >= CNT_W'(2)) && (CFG_DEAD < CFG_HALF);
    for (int k = 0; k < NUM_CH; k++) begin
      if (PHASE_SEL[k*PW +: PW] >= {CFG_HALF, 1'b0}) load_legal = 1'b0;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sync_q      <= 1'b0;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
      act_half_q  <= CNT_W'(DEF_HALF);
      act_dead_q  <= CNT_W'(DEF_DEAD);
      act_phase_q <= '0;
      shd_half_q  <= CNT_W'(DEF_HALF);
      shd_dead_q  <= CNT_W'(DEF_DEAD);
      shd_phase_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (ENABLE) begin
        state_q <= ST_RUN;
        cnt_q   <= wrap ? '0 : (cnt_q + PW'(1));
        sync_q  <= (cnt_q == '0);
      end else begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        sync_q  <= 1'b0;
      end
      if (apply) begin
        act_half_q  <= shd_half_q;
        act_dead_q  <= shd_dead_q;
        act_phase_q <= shd_phase_q;
        pending_q   <= 1'b0;
      end else if (CFG_LOAD && !pending_q) begin
        if (load_legal) begin
          shd_half_q  <= CFG_HALF;
          shd_dead_q  <= CFG_DEAD;
          shd_phase_q <= PHASE_SEL;
          pending_q   <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  clkgen_cfg_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) act_if ();

  assign act_if.half  = act_half_q;
  assign act_if.dead  = act_dead_q;
  assign act_if.phase = act_phase_q;
  assign act_if.state = state_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    nonoverlap_phase_slice #(.CNT_W(CNT_W), .CH(k)) u_slice (
      .clk_i  (CLK_IN),
      .rst_ni (RESET_N),
      .run_i  (ENABLE),
      .cnt_i  (cnt_q),
      .cfg    (act_if.slave),
      .mod_o  (CLK_OUT_MOD[k]),
      .modn_o (CLK_OUT_MODN[k])
    );
  end

  assign CFG_PENDING = pending_q;
  assign CFG_ERR     = err_q;
  assign SYNC        = sync_q;
endmodule

// File: tb/tb_multiphase_nonoverlap_clkgen.sv
// Self-checking bench: waveform table, hand-written config/reset sequences, randomized run vs model.
module tb_multiphase_nonoverlap_clkgen;
  import clkgen_pkg::*;

  localparam int NCH = 2;
  localparam int CW  = 6;
  localparam int PW  = CW + 1;

  logic clk = 1'b0;
  logic rst_n, en, load;
  logic cfg_pending, cfg_err, sync;
  logic [NCH-1:0] mod, modn;

  clkgen_cfg_if #(.NUM_CH(NCH), .CNT_W(CW)) stim ();

  always #5 clk = ~clk;

  multiphase_nonoverlap_clkgen #(.NUM_CH(NCH), .CNT_W(CW), .DEF_HALF(8), .DEF_DEAD(1)) dut (
    .CLK_IN       (clk),
    .RESET_N      (rst_n),
    .ENABLE       (en),
    .CFG_HALF     (stim.half),
    .CFG_DEAD     (stim.dead),
    .PHASE_SEL    (stim.phase),
    .CFG_LOAD     (load),
    .CFG_PENDING  (cfg_pending),
    .CFG_ERR      (cfg_err),
    .CLK_OUT_MOD  (mod),
    .CLK_OUT_MODN (modn),
    .SYNC         (sync)
  );

  assign stim.state = dut.state_q;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integer arithmetic over the period.
  int m_cnt, m_half, m_dead, s_half, s_dead;
  int m_ph[NCH];
  int s_ph[NCH];
  bit m_run, m_pend, m_err, m_sync;
  bit [NCH-1:0] m_mod, m_modn;

  typedef struct {
    logic en;
    logic exp_mod;
    logic exp_modn;
    logic exp_sync;
  } vec_t;
  vec_t tbl[34];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t state=%s)", name, act, exp, $time, stim.state.name());
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_pend = 0; m_err = 0; m_sync = 0;
    m_mod = '0; m_modn = '0;
    m_half = 8; m_dead = 1; s_half = 8; s_dead = 1;
    for (int k = 0; k < NCH; k++) begin m_ph[k] = 0; s_ph[k] = 0; end
  endtask

  task automatic model_step();
    int per, p, h, d;
    bit pend0, legal;
    if (!rst_n) begin
      model_reset();
      return;
    end
    per   = 2 * m_half;
    pend0 = m_pend;
    m_err = 0;
    for (int k = 0; k < NCH; k++) begin
      p = (m_cnt - m_ph[k] + per) % per;
      m_mod[k]  = en && (p >= m_dead) && (p < m_half);
      m_modn[k] = en && (p >= m_half + m_dead) && (p < per);
    end
    m_sync = en && (m_cnt == 0);
    if (pend0 && (!en || !m_run || (m_cnt == per - 1))) begin
      m_half = s_half; m_dead = s_dead;
      for (int k = 0; k < NCH; k++) m_ph[k] = s_ph[k];
      m_pend = 0;
    end else if (load && !pend0) begin
      h = int'(stim.half);
      d = int'(stim.dead);
      legal = (h >= 2) && (d < h);
      for (int k = 0; k < NCH; k++)
        if (int'(stim.phase[k*PW +: PW]) >= 2 * h) legal = 0;
      if (legal) begin
        s_half = h; s_dead = d;
        for (int k = 0; k < NCH; k++) s_ph[k] = int'(stim.phase[k*PW +: PW]);
        m_pend = 1;
      end else begin
        m_err = 1;
      end
    end
    m_cnt = en ? (m_cnt + 1) % per : 0;
    m_run = en;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("cycle_vs_model", {25'd0, mod, modn, sync, cfg_pending, cfg_err},
          {25'd0, m_mod, m_modn, m_sync, m_pend, m_err});
    check("no_overlap", 32'(mod & modn), 32'd0);
    @(negedge clk);
  endtask

  task automatic set_cfg(input int h, input int d, input int p0, input int p1);
    stim.half  = CW'(h);
    stim.dead  = CW'(d);
    stim.phase = {PW'(p1), PW'(p0)};
  endtask

  task automatic run_table();
    for (int i = 0; i < 34; i++) begin
      en = tbl[i].en;
      cyc();
      check($sformatf("table[%0d]", i), {29'd0, mod[0], modn[0], sync},
            {29'd0, tbl[i].exp_mod, tbl[i].exp_modn, tbl[i].exp_sync});
      check($sformatf("table_ch1[%0d]", i), {30'd0, mod[1], modn[1]},
            {30'd0, tbl[i].exp_mod, tbl[i].exp_modn});
    end
  endtask

  task automatic wait_cnt(input int target);
    int guard = 0;
    while (m_cnt != target && guard < 64) begin cyc(); guard++; end
    check("wait_cnt_timeout", 32'(guard >= 64), 32'd0);
  endtask

  bit [1:0] h0[1000];
  int cnt_pend, last_sync, gap;

  initial begin
    // Default waveform: CNT 0 and 8 both low, 1..7 MOD, 9..15 MODN; then two idle cycles.
    for (int i = 0; i < 32; i++) begin
      tbl[i].en       = 1'b1;
      tbl[i].exp_sync = ((i % 16) == 0);
      tbl[i].exp_mod  = ((i % 16) >= 1) && ((i % 16) <= 7);
      tbl[i].exp_modn = ((i % 16) >= 9);
    end
    for (int i = 32; i < 34; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    set_cfg(8, 1, 0, 0);
    model_reset();
    @(negedge clk);
    repeat (3) cyc();
    check("reset_outputs", {25'd0, mod, modn, sync, cfg_pending, cfg_err}, 32'd0);
    rst_n = 1'b1;
    cyc();

    run_table();

    // Channel 1 offset by 4: identical to channel 0 delayed by four cycles.
    set_cfg(8, 1, 0, 4);
    load = 1'b1; cyc(); load = 1'b0;
    check("phase_load_pending", 32'(cfg_pending), 32'd1);
    cyc();
    check("phase_idle_apply", 32'(cfg_pending), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      h0[i] = {mod[0], modn[0]};
      if (i >= 4) check("ch1_delay4", 32'({mod[1], modn[1]}), 32'(h0[i-4]));
    end

    // Mid-period reconfiguration to HALF=4, DEAD=0 loaded at CNT=5.
    en = 1'b0; set_cfg(8, 1, 0, 0);
    load = 1'b1; cyc(); load = 1'b0; cyc();
    en = 1'b1;
    wait_cnt(5);
    set_cfg(4, 0, 0, 0);
    load = 1'b1; cyc(); load = 1'b0;
    check("midload_pending", 32'(cfg_pending), 32'd1);
    cnt_pend = 0;
    while (cfg_pending && cnt_pend < 40) begin cyc(); cnt_pend++; end
    check("pending_until_wrap", 32'(cnt_pend), 32'd10);
    for (int i = 0; i < 16; i++) begin
      cyc();
      check("complementary", 32'(mod[0] ^ modn[0]), 32'd1);
      check("sync_period8", 32'(sync), 32'((i % 8) == 0));
    end

    // Illegal DEAD=HALF rejected with a single error pulse; load while pending ignored.
    set_cfg(8, 8, 0, 0);
    load = 1'b1; cyc(); load = 1'b0;
    check("err_pulse", {30'd0, cfg_err, cfg_pending}, 32'b10);
    cyc();
    check("err_single", 32'(cfg_err), 32'd0);
    set_cfg(8, 1, 0, 0);
    load = 1'b1; cyc();
    check("legal_pending", 32'(cfg_pending), 32'd1);
    set_cfg(5, 2, 0, 0);
    cyc(); load = 1'b0;
    check("ignored_no_err", 32'(cfg_err), 32'd0);
    cnt_pend = 0;
    while (cfg_pending && cnt_pend < 40) begin cyc(); cnt_pend++; end
    check("second_apply_timeout", 32'(cnt_pend >= 40), 32'd0);
    last_sync = -1; gap = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (sync) begin
        if (last_sync >= 0) begin gap = i - last_sync; check("period16_after_ignore", 32'(gap), 32'd16); end
        last_sync = i;
      end
    end

    // Reset at CNT=10 with a config pending.
    wait_cnt(3);
    set_cfg(4, 0, 0, 0);
    load = 1'b1; cyc(); load = 1'b0;
    wait_cnt(10);
    check("pending_before_reset", 32'(cfg_pending), 32'd1);
    rst_n = 1'b0; cyc();
    check("reset_midperiod", {25'd0, mod, modn, sync, cfg_pending, cfg_err}, 32'd0);
    rst_n = 1'b1;
    run_table();

    // Randomized mix of enable, loads (legal and illegal) and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      load = 1'b0;
      if ($urandom_range(0, 63) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) begin
        set_cfg($urandom_range(0, 20), $urandom_range(0, 12), $urandom_range(0, 40), $urandom_range(0, 40));
        load = 1'b1;
      end
      rst_n = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rst_n = 1'b1; load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multiphase_nonoverlap_clkgen.md
MULTIPHASE_NONOVERLAP_CLKGEN -- requirements
Module: multiphase_nonoverlap_clkgen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of output channel pairs (1..8).
REQ-002 SHALL have parameter CNT_W, default 6, width of the half-period, dead-time and phase fields.
REQ-003 SHALL have parameter DEF_HALF, default 8, half-period in CLK_IN cycles applied at reset.
REQ-004 SHALL have parameter DEF_DEAD, default 1, dead time in CLK_IN cycles applied at reset.
REQ-005 SHALL have port CLK_IN  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port RESET_N  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port ENABLE  in  1  run when high; hold idle when low.
REQ-008 SHALL have port CFG_HALF  in  CNT_W  requested half-period.
REQ-009 SHALL have port CFG_DEAD  in  CNT_W  requested dead time.
REQ-010 SHALL have port PHASE_SEL  in  NUM_CH*CNT_W+NUM_CH  per-channel phase offset, CNT_W+1 bits each; channel k in slice k.
REQ-011 SHALL have port CFG_LOAD  in  1  single-cycle request to capture CFG_HALF, CFG_DEAD and PHASE_SEL.
REQ-012 SHALL have port CFG_PENDING  out  1  captured config not yet applied.
REQ-013 SHALL have port CFG_ERR  out  1  one-cycle pulse when a load is rejected.
REQ-014 SHALL have port CLK_OUT_MOD  out  NUM_CH  per-channel phase A.
REQ-015 SHALL have port CLK_OUT_MODN  out  NUM_CH  per-channel phase B, never overlapping A.
REQ-016 SHALL have port SYNC  out  1  one-cycle pulse, aligned with outputs, at counter value 0.

Function
REQ-017 SHALL have a base counter CNT, CNT_W+1 bits, running 0..2*HALF-1 and wrapping to 0.
REQ-018 SHALL implement two states. IDLE: CNT=0, all outputs low. RUN: CNT advances each cycle.
REQ-019 SHALL move IDLE->RUN on the first cycle ENABLE=1, with CNT=0 in that cycle. SHALL move RUN->IDLE in the cycle ENABLE=0 is sampled, with outputs low from the following cycle.
REQ-020 SHALL compute per channel P = (CNT - PHASE_k) mod 2*HALF at CNT_W+1 bits, with no overflow for legal values.
REQ-021 SHALL drive CLK_OUT_MOD[k] high iff DEAD <= P < HALF, and CLK_OUT_MODN[k] high iff HALF+DEAD <= P < 2*HALF.
REQ-022 SHALL register all outputs: one CLK_IN cycle latency from CNT to pins, glitch-free.
REQ-023 SHALL make the outputs exactly complementary when DEAD=0; MOD and MODN SHALL never be high together for any legal config.
REQ-024 SHALL treat a load as legal iff HALF>=2, DEAD<HALF and every PHASE_k<2*HALF.
REQ-025 SHALL accept CFG_LOAD only when CFG_PENDING=0.
- Legal load: capture into the shadow register; CFG_PENDING=1 from the next cycle.
- Illegal load: CFG_ERR pulses the next cycle; shadow and active config unchanged.
REQ-026 SHALL ignore CFG_LOAD while CFG_PENDING=1: no capture, no CFG_ERR.
REQ-027 SHALL copy shadow to active on the RUN-cycle where CNT wraps 2*HALF-1->0, or on the next cycle if in IDLE; CFG_PENDING SHALL clear in the same cycle.
REQ-028 SHALL keep a period started under the old config completing under the old config; no truncated or stretched pulses.
REQ-029 SHALL give RESET_N=0 priority over ENABLE and CFG_LOAD.

Reset
REQ-030 SHALL on RESET_N=0 at a clock edge force: IDLE, CNT=0, all outputs 0, CFG_PENDING=0, CFG_ERR=0, active and shadow HALF=DEF_HALF, DEAD=DEF_DEAD, all PHASE=0.
REQ-031 SHALL, when reset is asserted mid-period, drop outputs low on the next edge and discard any pending config.

Structure
REQ-032 SHALL place CNT_W default, DEF_HALF, DEF_DEAD and the state encodings in shared package clkgen_pkg.
REQ-033 SHALL instantiate sub-module nonoverlap_phase_slice NUM_CH times (phase subtract, window compare, output registers); the base counter and config handshake remain in the top module.

Verification
REQ-034 Defaults, PHASE=0, ENABLE rises -> period 16 cycles; MOD high 7, then both low 1, MODN high 7, both low 1; SYNC every 16 cycles.
REQ-035 NUM_CH=2, PHASE_SEL ch1=4 -> ch1 waveforms identical to ch0 delayed by exactly 4 cycles; no MOD/MODN overlap on any channel over 1000 cycles.
REQ-036 CFG_LOAD HALF=4, DEAD=0 at CNT=5 -> CFG_PENDING high until wrap; old 16-cycle period completes, next period is 8 cycles with complementary outputs.
REQ-037 CFG_LOAD DEAD=8 with HALF=8 -> CFG_ERR one pulse; waveform unchanged. Second CFG_LOAD while pending -> ignored.
REQ-038 RESET_N=0 at CNT=10 with a config pending -> outputs 0 next cycle, CFG_PENDING=0; after release, default 16-cycle waveform restarts from CNT=0.
